// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encoding, ACK/NACK bus levels and a majority-vote helper.
// Used by the register-file slave and the bus master.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DEV_ADDR,
    ST_DEV_ACK,
    ST_REG_PTR,
    ST_PTR_ACK,
    ST_WR_DATA,
    ST_WR_ACK,
    ST_RD_DATA,
    ST_RD_ACK
  } i2c_state_e;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchroniser with optional 3-sample majority filter (I2C_SLAVE_GLITCH_FILTER_EN, +2 cycles),
// producing SCL edge pulses and START/STOP strobes; latency SYNC_STAGES+1 cycles, no backpressure.
module i2c_bus_sync
  import i2c_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic                   scl_s;
  logic                   sda_s;
  logic                   scl_f;
  logic                   sda_f;
  logic                   scl_prev_q;
  logic                   sda_prev_q;

  // Idle bus level is high, so everything resets to 1 to avoid phantom edges.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
    end
  end

  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  logic [1:0] scl_hist_q;
  logic [1:0] sda_hist_q;
  logic       scl_filt_q;
  logic       sda_filt_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      scl_hist_q <= 2'b11;
      sda_hist_q <= 2'b11;
      scl_filt_q <= 1'b1;
      sda_filt_q <= 1'b1;
    end else begin
      scl_hist_q <= {scl_hist_q[0], scl_s};
      sda_hist_q <= {sda_hist_q[0], sda_s};
      scl_filt_q <= maj3(scl_s, scl_hist_q[0], scl_hist_q[1]);
      sda_filt_q <= maj3(sda_s, sda_hist_q[0], sda_hist_q[1]);
    end
  end

  assign scl_f = scl_filt_q;
  assign sda_f = sda_filt_q;
`else
  assign scl_f = scl_s;
  assign sda_f = sda_s;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_prev_q <= scl_f;
      sda_prev_q <= sda_f;
    end
  end

  assign sda_o      = sda_f;
  assign scl_rise_o = scl_f & ~scl_prev_q;
  assign scl_fall_o = ~scl_f & scl_prev_q;
  assign start_o    = scl_f & scl_prev_q & sda_prev_q & ~sda_f;
  assign stop_o     = scl_f & scl_prev_q & ~sda_prev_q & sda_f;

endmodule

// File: rtl/i2c_regfile_slave.sv
// I2C slave exposing a 256x8 register file with auto-incrementing pointer; optional I2C_SLAVE_GLITCH_FILTER_EN.
// Bus events seen SYNC_STAGES+1 cycles after the pins; wr_strobe one cycle after the 8th bit; no clock stretching.
module i2c_regfile_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0] CHIP_ADDR   = 7'd72,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       SCL,
  inout  wire        SDA,
  input  logic [7:0] dbg_addr,
  output logic [7:0] dbg_data,
  output logic       wr_strobe,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy
);

  i2c_state_e state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] ptr_q, ptr_d;
  logic       sda_oe_q, sda_oe_d;
  logic       ack_q, ack_d;
  logic       wr_pend_q, wr_pend_d;
  logic       busy_q, busy_d;
  logic       wr_strobe_q;
  logic [7:0] wr_addr_q;
  logic [7:0] wr_data_q;
  logic [7:0] regs_q [256];

  logic       sda_s;
  logic       scl_rise;
  logic       scl_fall;
  logic       start_det;
  logic       stop_det;
  logic       byte_done;
  logic       addr_match;
  logic [7:0] ptr_inc;
  logic [7:0] rd_byte;
  logic [7:0] rd_byte_next;

  i2c_bus_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_bus_sync (
    .clock     (clock),
    .reset     (reset),
    .scl_i     (SCL),
    .sda_i     (SDA),
    .sda_o     (sda_s),
    .scl_rise_o(scl_rise),
    .scl_fall_o(scl_fall),
    .start_o   (start_det),
    .stop_o    (stop_det)
  );

  assign SDA          = sda_oe_q ? 1'b0 : 1'bz;
  assign byte_done    = (bit_cnt_q == 4'd8);
  assign addr_match   = (shift_q[7:1] == CHIP_ADDR);
  assign ptr_inc      = ptr_q + 8'd1;
  assign rd_byte      = regs_q[ptr_q];
  assign rd_byte_next = regs_q[ptr_inc];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 4'd0;
      shift_q     <= 8'h00;
      ptr_q       <= 8'h00;
      sda_oe_q    <= 1'b0;
      ack_q       <= I2C_NACK;
      wr_pend_q   <= 1'b0;
      busy_q      <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= 8'h00;
      wr_data_q   <= 8'h00;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      ptr_q       <= ptr_d;
      sda_oe_q    <= sda_oe_d;
      ack_q       <= ack_d;
      wr_pend_q   <= wr_pend_d;
      busy_q      <= busy_d;
      wr_strobe_q <= wr_pend_q;
      if (wr_pend_q) begin
        wr_addr_q <= ptr_q;
        wr_data_q <= shift_q;
      end
    end
  end

  // Commit lands the cycle after the last bit; ptr and shift are stable until the ACK clock.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 256; i++) regs_q[i] <= 8'h00;
    end else if (wr_pend_q) begin
      regs_q[ptr_q] <= shift_q;
    end
  end

  always_comb begin
    state_d = state_q;
    if (start_det) begin
      state_d = ST_DEV_ADDR;
    end else if (stop_det) begin
      state_d = ST_IDLE;
    end else if (scl_fall) begin
      case (state_q)
        ST_DEV_ADDR: if (byte_done) state_d = addr_match ? ST_DEV_ACK : ST_IDLE;
        ST_DEV_ACK:  state_d = shift_q[0] ? ST_RD_DATA : ST_REG_PTR;
        ST_REG_PTR:  if (byte_done) state_d = ST_PTR_ACK;
        ST_PTR_ACK:  state_d = ST_WR_DATA;
        ST_WR_DATA:  if (byte_done) state_d = ST_WR_ACK;
        ST_WR_ACK:   state_d = ST_WR_DATA;
        ST_RD_DATA:  if (byte_done) state_d = ST_RD_ACK;
        ST_RD_ACK:   state_d = (ack_q == I2C_ACK) ? ST_RD_DATA : ST_IDLE;
        default:     state_d = state_q;
      endcase
    end
  end

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    ptr_d     = ptr_q;
    sda_oe_d  = sda_oe_q;
    ack_d     = ack_q;
    wr_pend_d = 1'b0;
    busy_d    = busy_q;
    if (start_det) begin
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b1;
    end else if (stop_det) begin
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      case (state_q)
        ST_DEV_ADDR, ST_REG_PTR, ST_WR_DATA: begin
          if (scl_rise && !byte_done) begin
            shift_d   = {shift_q[6:0], sda_s};
            bit_cnt_d = bit_cnt_q + 4'd1;
            wr_pend_d = (state_q == ST_WR_DATA) && (bit_cnt_q == 4'd7);
          end
          if (scl_fall && byte_done) begin
            // A non-matching address is NACKed by simply never pulling SDA low.
            sda_oe_d = (state_q != ST_DEV_ADDR) || addr_match;
            if (state_q == ST_REG_PTR) ptr_d = shift_q;
          end
        end
        ST_DEV_ACK: begin
          if (scl_fall) begin
            bit_cnt_d = 4'd0;
            if (shift_q[0]) begin
              shift_d  = rd_byte;
              sda_oe_d = ~rd_byte[7];
            end else begin
              sda_oe_d = 1'b0;
            end
          end
        end
        ST_PTR_ACK: begin
          if (scl_fall) begin
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
          end
        end
        ST_WR_ACK: begin
          if (scl_fall) begin
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
            ptr_d     = ptr_inc;
          end
        end
        ST_RD_DATA: begin
          if (scl_rise && !byte_done) bit_cnt_d = bit_cnt_q + 4'd1;
          if (scl_fall) begin
            if (byte_done) begin
              sda_oe_d = 1'b0;
            end else begin
              sda_oe_d = ~shift_q[6];
              shift_d  = {shift_q[6:0], 1'b0};
            end
          end
        end
        ST_RD_ACK: begin
          if (scl_rise) ack_d = sda_s;
          if (scl_fall) begin
            if (ack_q == I2C_ACK) begin
              ptr_d     = ptr_inc;
              shift_d   = rd_byte_next;
              sda_oe_d  = ~rd_byte_next[7];
              bit_cnt_d = 4'd0;
            end else begin
              sda_oe_d = 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign dbg_data  = regs_q[dbg_addr];
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_regfile_slave.sv
// Directed bench for i2c_regfile_slave: bit-banged I2C master with a pulled-up SDA line,
// hand-computed expectations for write, read, wrong address, wrap, abort and mid-read reset.
module tb_i2c_regfile_slave;
  import i2c_pkg::*;

  localparam int Q = 200;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       scl   = 1'b1;
  logic       m_low = 1'b0;
  logic [7:0] dbg_addr = 8'h00;
  wire  [7:0] dbg_data;
  wire  [7:0] wr_addr;
  wire  [7:0] wr_data;
  wire        wr_strobe;
  wire        busy;
  wire        sda_bus;

  int n_checks = 0;
  int n_fail   = 0;
  int strb_cnt = 0;

  assign sda_bus = m_low ? 1'b0 : 1'bz;
  pullup (sda_bus);

  i2c_regfile_slave dut (
    .clock    (clock),
    .reset    (reset),
    .SCL      (scl),
    .SDA      (sda_bus),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .wr_strobe(wr_strobe),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy)
  );

  always #5 clock = ~clock;

  // Counts high cycles, so a stretched strobe shows up as an extra count.
  always @(negedge clock) if (wr_strobe === 1'b1) strb_cnt++;

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic peek(input logic [7:0] addr, input string tag, input logic [7:0] exp);
    dbg_addr = addr;
    #1;
    check_eq(tag, {24'd0, dbg_data}, {24'd0, exp});
  endtask

  task automatic bus_start();
    m_low = 1'b0; #Q;
    scl   = 1'b1; #Q;
    m_low = 1'b1; #Q;
    scl   = 1'b0; #Q;
  endtask

  task automatic bus_stop();
    m_low = 1'b1; #Q;
    scl   = 1'b1; #Q;
    m_low = 1'b0; #Q;
  endtask

  task automatic send_bit(input logic b);
    m_low = ~b; #Q;
    scl   = 1'b1; #(2 * Q);
    scl   = 1'b0; #Q;
  endtask

  task automatic recv_bit(output logic b);
    m_low = 1'b0; #Q;
    scl   = 1'b1; #Q;
    b     = sda_bus; #Q;
    scl   = 1'b0; #Q;
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    recv_bit(ack);
  endtask

  task automatic recv_byte(output logic [7:0] d, input logic nack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      d[i] = b;
    end
    send_bit(nack);
  endtask

  initial begin
    logic       a0, a1, a2, a3;
    logic       b;
    logic [7:0] d;

    // Reset state
    repeat (10) @(posedge clock);
    #1;
    check_eq("rst_wr_strobe", {31'd0, wr_strobe}, 32'd0);
    check_eq("rst_wr_addr", {24'd0, wr_addr}, 32'd0);
    check_eq("rst_wr_data", {24'd0, wr_data}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_sda", {31'd0, sda_bus}, 32'd1);
    peek(8'h41, "rst_reg41", 8'h00);
    reset = 1'b1;
    #(2 * Q);

    // Write 0x10 to register 0x41
    bus_start();
    check_eq("busy_after_start", {31'd0, busy}, 32'd1);
    send_byte(8'h90, a0);
    send_byte(8'h41, a1);
    send_byte(8'h10, a2);
    bus_stop();
    check_eq("wr_ack_addr", {31'd0, a0}, 32'd0);
    check_eq("wr_ack_ptr", {31'd0, a1}, 32'd0);
    check_eq("wr_ack_data", {31'd0, a2}, 32'd0);
    check_eq("wr_strobe_cnt", strb_cnt, 32'd1);
    check_eq("wr_addr", {24'd0, wr_addr}, 32'h41);
    check_eq("wr_data", {24'd0, wr_data}, 32'h10);
    check_eq("busy_after_stop", {31'd0, busy}, 32'd0);
    peek(8'h41, "reg41_written", 8'h10);

    // Read it back with a repeated START
    bus_start();
    send_byte(8'h90, a0);
    send_byte(8'h41, a1);
    bus_start();
    send_byte(8'h91, a2);
    recv_byte(d, 1'b1);
    check_eq("rd_acks", {29'd0, a0, a1, a2}, 32'd0);
    check_eq("rd_data", {24'd0, d}, 32'h10);
    check_eq("rd_state_idle", {28'd0, dut.state_q}, {28'd0, ST_IDLE});
    bus_stop();

    // Wrong device address
    bus_start();
    send_byte(8'h72, a0);
    check_eq("wrong_addr_nack", {31'd0, a0}, 32'd1);
    check_eq("wrong_addr_idle", {28'd0, dut.state_q}, {28'd0, ST_IDLE});
    bus_stop();
    peek(8'h41, "wrong_addr_reg41", 8'h10);
    check_eq("wrong_addr_strb", strb_cnt, 32'd1);

    // Pointer wrap on write
    bus_start();
    send_byte(8'h90, a0);
    send_byte(8'hFF, a1);
    send_byte(8'hAA, a2);
    send_byte(8'hBB, a3);
    bus_stop();
    check_eq("wrap_acks", {28'd0, a0, a1, a2, a3}, 32'd0);
    peek(8'hFF, "wrap_regFF", 8'hAA);
    peek(8'h00, "wrap_reg00", 8'hBB);
    check_eq("wrap_strb", strb_cnt, 32'd3);
    check_eq("wrap_wr_addr", {24'd0, wr_addr}, 32'h00);
    check_eq("wrap_wr_data", {24'd0, wr_data}, 32'hBB);

    // Pointer wrap on a two-byte read
    bus_start();
    send_byte(8'h90, a0);
    send_byte(8'hFF, a1);
    bus_start();
    send_byte(8'h91, a2);
    recv_byte(d, 1'b0);
    check_eq("rdwrap_byte0", {24'd0, d}, 32'hAA);
    recv_byte(d, 1'b1);
    check_eq("rdwrap_byte1", {24'd0, d}, 32'hBB);
    bus_stop();

    // STOP after 5 data bits abandons the byte
    bus_start();
    send_byte(8'h90, a0);
    send_byte(8'h20, a1);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    bus_stop();
    check_eq("abort_strb", strb_cnt, 32'd3);
    peek(8'h20, "abort_reg20", 8'h00);
    check_eq("abort_busy", {31'd0, busy}, 32'd0);

    // Reset while the slave is driving a 0 read bit (0xAA bit 6)
    bus_start();
    send_byte(8'h90, a0);
    send_byte(8'hFF, a1);
    bus_start();
    send_byte(8'h91, a2);
    recv_bit(b);
    check_eq("midrd_bit7", {31'd0, b}, 32'd1);
    check_eq("midrd_sda_low", {31'd0, sda_bus}, 32'd0);
    check_eq("midrd_state", {28'd0, dut.state_q}, {28'd0, ST_RD_DATA});
    @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    check_eq("rst_sda_release", {31'd0, sda_bus}, 32'd1);
    check_eq("rst_busy2", {31'd0, busy}, 32'd0);
    check_eq("rst_wr_data2", {24'd0, wr_data}, 32'd0);
    check_eq("rst_wr_strobe2", {31'd0, wr_strobe}, 32'd0);
    check_eq("rst_state2", {28'd0, dut.state_q}, {28'd0, ST_IDLE});
    peek(8'hFF, "rst_regFF", 8'h00);
    peek(8'h41, "rst_reg41b", 8'h00);

    // After reset release the bus is ignored until a START
    #Q;
    reset = 1'b1;
    for (int i = 0; i < 9; i++) send_bit(1'b0);
    check_eq("post_rst_idle", {28'd0, dut.state_q}, {28'd0, ST_IDLE});
    check_eq("post_rst_busy", {31'd0, busy}, 32'd0);
    check_eq("post_rst_sda", {31'd0, sda_bus}, 32'd0);
    m_low = 1'b0;
    #Q;
    scl = 1'b1;
    #Q;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
